// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 11;
    localparam int unsigned UART_DATA_W               = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Byte output channel of the UART receiver: valid/ready data plus error pulses.
interface uart_receiver_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] data;
    logic                   valid;
    logic                   ready;
    logic                   frame_err;
    logic                   overrun;

    modport master (
        output data,
        output valid,
        input  ready,
        output frame_err,
        output overrun
    );

    modport slave (
        input  data,
        input  valid,
        output ready,
        input  frame_err,
        input  overrun
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an idle-high asynchronous line; resets to 1.
module uart_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Capture the asynchronous input, then re-register to settle metastability.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start validation, mid-bit sampling, stop check and a
// one-entry valid/ready output register with framing and overrun pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_rx,
    uart_receiver_if.master bus
);

    localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
    // The first START cycle follows the entry edge, so a count of HALF-1 marks
    // the HALF-th edge after entry, which is the start-bit mid-point.
    localparam logic [7:0] START_LAST = 8'(HALF - 1);
    localparam logic [7:0] BIT_LAST   = 8'(CLKS_PER_BIT - 1);

    logic                   w_rx_s;
    rx_state_t              r_state,     w_state_next;
    logic [7:0]             r_cnt,       w_cnt_next;
    logic [2:0]             r_bidx,      w_bidx_next;
    logic [UART_DATA_W-1:0] r_shift,     w_shift_next;
    logic [UART_DATA_W-1:0] r_data,      w_data_next;
    logic                   r_valid,     w_valid_next;
    logic                   r_frame_err, w_frame_err_next;
    logic                   r_overrun,   w_overrun_next;

    uart_sync2 u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx),
        .o_q     (w_rx_s)
    );

    // State, counters, shift register and output register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_bidx      <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_bidx      <= w_bidx_next;
            r_shift     <= w_shift_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_frame_err_next;
            r_overrun   <= w_overrun_next;
        end
    end

    // Next-state logic: frame sequencing and output-register handshake.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_bidx_next      = r_bidx;
        w_shift_next     = r_shift;
        w_data_next      = r_data;
        w_valid_next     = r_valid & ~bus.ready;
        w_frame_err_next = 1'b0;
        w_overrun_next   = 1'b0;

        case (r_state)
            StIdle: begin
                if (!w_rx_s) begin
                    w_state_next = StStart;
                    w_cnt_next   = '0;
                end
            end
            StStart: begin
                if (r_cnt == START_LAST) begin
                    w_cnt_next  = '0;
                    w_bidx_next = '0;
                    // A line already back high at mid-start is a glitch.
                    w_state_next = w_rx_s ? StIdle : StData;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            StData: begin
                if (r_cnt == BIT_LAST) begin
                    w_shift_next[r_bidx] = w_rx_s;
                    w_cnt_next           = '0;
                    w_bidx_next          = r_bidx + 3'd1;
                    if (r_bidx == 3'd7) begin
                        w_state_next = StStop;
                    end
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            StStop: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_state_next = StIdle;
                        // Load when empty or when the held byte leaves this edge.
                        if (!r_valid || bus.ready) begin
                            w_data_next  = r_shift;
                            w_valid_next = 1'b1;
                        end else begin
                            w_overrun_next = 1'b1;
                        end
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = StBreak;
                    end
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            StBreak: begin
                if (w_rx_s) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized
// frames compared against a queue-based expectation of delivered bytes.
module tb_uart_receiver;

    localparam int C    = 11;
    localparam int HALF = (C - 1) / 2;
    localparam int LAT  = 2 + HALF + 9 * C;  // E to stop-sample edge

    logic clk;
    logic rst_n;
    logic rx;
    logic ready;
    bit   rand_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Monitor state
    int         vrise_cnt = 0;
    int         vhigh_cnt = 0;
    int         fe_cnt    = 0;
    int         ov_cnt    = 0;
    int         hold_err  = 0;
    int         rise_cyc  = 0;
    logic [7:0] rise_data = '0;
    logic [7:0] got_q[$];
    logic       mon_pv    = 1'b0;
    logic       mon_pacc  = 1'b0;
    logic [7:0] mon_pd    = '0;

    uart_receiver_if bus_if ();
    assign bus_if.ready = ready;

    uart_receiver #(
        .CLKS_PER_BIT (C)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_rx    (rx),
        .bus     (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle: accepted bytes, pulse widths, hold stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_pv   <= 1'b0;
            mon_pacc <= 1'b0;
        end else begin
            if (bus_if.valid && !mon_pv) begin
                vrise_cnt <= vrise_cnt + 1;
                rise_cyc  <= cyc;
                rise_data <= bus_if.data;
            end
            if (bus_if.valid)     vhigh_cnt <= vhigh_cnt + 1;
            if (bus_if.frame_err) fe_cnt    <= fe_cnt + 1;
            if (bus_if.overrun)   ov_cnt    <= ov_cnt + 1;
            if (bus_if.valid && ready) got_q.push_back(bus_if.data);
            if (mon_pv && !mon_pacc && bus_if.valid && bus_if.data != mon_pd)
                hold_err <= hold_err + 1;
            mon_pv   <= bus_if.valid;
            mon_pacc <= bus_if.valid && ready;
            mon_pd   <= bus_if.data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n clocks, staying at posedge+1.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rand_ready) ready = 1'($urandom_range(1, 0));
        end
    endtask

    // Drive the first nbits of {stop, byte, start} LSB first; line left idle.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = fr[i];
            idle(C);
        end
        rx = 1'b1;
    endtask

    task automatic expect_accept(input string tag, input int base, input logic [7:0] exp);
        check_eq({tag, "_cnt"}, 32'(got_q.size() - base), 32'd1);
        if (got_q.size() > base) check_eq({tag, "_byte"}, 32'(got_q[base]), 32'(exp));
    endtask

    initial begin
        int         base;
        int         fe0;
        int         ov0;
        int         vr0;
        int         vh0;
        int         t0;
        int         n_bad;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic       sb;

        rst_n      = 1'b0;
        rx         = 1'b1;
        ready      = 1'b0;
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(bus_if.valid), 32'd0);
        check_eq("rst_data", 32'(bus_if.data), 32'd0);
        check_eq("rst_fe", 32'(bus_if.frame_err), 32'd0);
        check_eq("rst_ov", 32'(bus_if.overrun), 32'd0);
        rst_n = 1'b1;
        idle(5);

        // Loopback 0xA5 with ready held high; exact stop-sample latency.
        ready = 1'b1;
        base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt; vh0 = vhigh_cnt;
        t0 = cyc;
        drive_frame(8'hA5, 1'b1, 10);
        idle(5);
        check_eq("lb_latency", 32'(rise_cyc - t0), 32'(LAT + 1));
        check_eq("lb_data", 32'(rise_data), 32'hA5);
        check_eq("lb_valid_cycles", 32'(vhigh_cnt - vh0), 32'd1);
        check_eq("lb_fe", 32'(fe_cnt - fe0), 32'd0);
        check_eq("lb_ov", 32'(ov_cnt - ov0), 32'd0);
        expect_accept("lb_acc", base, 8'hA5);

        // Glitch shorter than half a bit, then a real frame.
        vr0 = vrise_cnt; fe0 = fe_cnt;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);
        check_eq("gl_no_valid", 32'(vrise_cnt - vr0), 32'd0);
        check_eq("gl_no_fe", 32'(fe_cnt - fe0), 32'd0);
        base = got_q.size();
        drive_frame(8'h3C, 1'b1, 10);
        idle(4);
        expect_accept("gl_next", base, 8'h3C);

        // Framing error, line held low afterwards.
        vr0 = vrise_cnt; fe0 = fe_cnt;
        drive_frame(8'h81, 1'b0, 10);
        rx = 1'b0;
        idle(40);
        check_eq("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
        check_eq("fe_no_valid", 32'(vrise_cnt - vr0), 32'd0);
        rx = 1'b1;
        idle(20);
        check_eq("fe_break_quiet", 32'(fe_cnt - fe0), 32'd1);
        check_eq("fe_break_novalid", 32'(vrise_cnt - vr0), 32'd0);

        // Overrun: two bytes with ready low.
        ready = 1'b0;
        ov0 = ov_cnt; fe0 = fe_cnt;
        drive_frame(8'h11, 1'b1, 10);
        idle(8);
        drive_frame(8'h22, 1'b1, 10);
        idle(5);
        check_eq("ov_valid", 32'(bus_if.valid), 32'd1);
        check_eq("ov_data_kept", 32'(bus_if.data), 32'h11);
        check_eq("ov_pulse", 32'(ov_cnt - ov0), 32'd1);
        check_eq("ov_no_fe", 32'(fe_cnt - fe0), 32'd0);
        base = got_q.size();
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        check_eq("ov_drained", 32'(bus_if.valid), 32'd0);
        expect_accept("ov_acc", base, 8'h11);

        // Accept and load on the same edge.
        drive_frame(8'h11, 1'b1, 10);
        idle(8);
        ov0 = ov_cnt;
        base = got_q.size();
        fork
            drive_frame(8'h22, 1'b1, 10);
            begin
                repeat (LAT) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
            end
        join
        check_eq("sim_valid", 32'(bus_if.valid), 32'd1);
        check_eq("sim_data", 32'(bus_if.data), 32'h22);
        check_eq("sim_no_ov", 32'(ov_cnt - ov0), 32'd0);
        expect_accept("sim_acc", base, 8'h11);
        ready = 1'b1;
        idle(2);
        ready = 1'b0;

        // Reset during bit 4 with a byte held in the output register.
        drive_frame(8'h33, 1'b1, 10);
        idle(5);
        check_eq("rm_pre_valid", 32'(bus_if.valid), 32'd1);
        fork
            drive_frame(8'h77, 1'b1, 6);
            begin
                repeat (60) @(posedge clk);
                #3 rst_n = 1'b0;
                #1;
                check_eq("rm_valid", 32'(bus_if.valid), 32'd0);
                check_eq("rm_data", 32'(bus_if.data), 32'd0);
                check_eq("rm_fe", 32'(bus_if.frame_err), 32'd0);
                check_eq("rm_ov", 32'(bus_if.overrun), 32'd0);
                repeat (10) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        idle(5);
        ready = 1'b1;
        base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        drive_frame(8'h5A, 1'b1, 10);
        idle(4);
        expect_accept("rm_next", base, 8'h5A);
        check_eq("rm_next_fe", 32'(fe_cnt - fe0), 32'd0);
        check_eq("rm_next_ov", 32'(ov_cnt - ov0), 32'd0);

        // Randomized frames: random bytes, occasional bad stop, random ready.
        rand_ready = 1'b1;
        base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        n_bad = 0;
        for (int i = 0; i < 16; i++) begin
            b  = 8'($urandom_range(255, 0));
            sb = ($urandom_range(5, 0) != 0);
            if (sb) exp_q.push_back(b);
            else    n_bad++;
            drive_frame(b, sb, 10);
            idle($urandom_range(C + 3, 3));
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        idle(10);
        check_eq("rnd_count", 32'(got_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) check_eq("rnd_byte", 32'(got_q[base + i]), 32'(exp_q[i]));
        end
        check_eq("rnd_fe", 32'(fe_cnt - fe0), 32'(n_bad));
        check_eq("rnd_ov", 32'(ov_cnt - ov0), 32'd0);
        check_eq("data_hold", 32'(hold_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage, 8N1, LSB first, idle-high line. Consumes the bit stream produced by the existing UART transmitter (line `TX`, one bit per `CLKS_PER_BIT` clocks). It synchronises the asynchronous line, validates the start bit, and samples each bit at mid-period. It checks the stop bit and presents each received byte through a one-entry valid/ready output register, with framing and overrun indications.

## Interface
- `CLKS_PER_BIT`, 11: clocks per bit period. Matches transmitter `END_OF_COUNTER = 10`. Legal range 4..255.
- `HALF`, `(CLKS_PER_BIT-1)/2`: start-bit sample offset. Derived localparam, not overridable.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx` in 1: serial line, asynchronous to `clk`, idle 1.
- `data` out 8: received byte, stable while `valid`=1.
- `valid` out 1: byte available; held until accepted.
- `ready` in 1: consumer accepts byte when `valid & ready` on a rising edge.
- `frame_err` out 1: one-cycle pulse, stop bit sampled 0.
- `overrun` out 1: one-cycle pulse, byte completed while output register still full and not being accepted.

## Operation
- Reset (`rst_n`=0, any time, mid-frame included):
  - state IDLE, counters 0, shift register 0.
  - Synchroniser flops set to 1.
  - Outputs: `data`=0, `valid`=0, `frame_err`=0, `overrun`=0.
- `rx` passes through a 2-flop synchroniser; `rx_s` is the second-flop output. All decisions use `rx_s` only.
- States: IDLE, START, DATA, STOP, BREAK. Bit counter `cnt` is 8 bits wide; bit index `bidx` is 3 bits wide.
- IDLE: on `rx_s`=0, go to START with `cnt`←0.
- START: `cnt` increments each cycle. At `cnt`==HALF:
  - if `rx_s`=0, go to DATA with `cnt`←0, `bidx`←0.
  - else the start was a glitch; return to IDLE with no output.
- DATA: at `cnt`==CLKS_PER_BIT-1, shift `rx_s` into bit `bidx` (LSB first), `cnt`←0, `bidx`+1. After bit 7 is sampled, go to STOP.
- STOP: at `cnt`==CLKS_PER_BIT-1, sample `rx_s`.
  - `rx_s`=1, output register empty or being accepted this cycle: `data`←shift register, `valid`←1, go to IDLE.
  - `rx_s`=1, `valid`=1 and `ready`=0: the new byte is dropped, the old `data` is kept, `overrun` pulses, go to IDLE.
  - `rx_s`=0: byte discarded, `frame_err` pulses, go to BREAK.
- BREAK: wait for `rx_s`=1, then go to IDLE. A line held low never produces a second frame.
- Handshake:
  - `valid & ready` clears `valid` on the next edge.
  - If that same edge also loads a new byte, `valid` stays 1, `data` updates, and no overrun is raised.
- `ready` is ignored while `valid`=0. The receiver never stalls the line; reception continues regardless of `ready`.

## Timing
- Let E be the edge where the first synchroniser flop captures `rx`=0.
  - `rx_s`=0 after E+1.
  - START entered at E+2.
  - Start sample at E+2+HALF.
  - Data bit k sampled at E+2+HALF+(k+1)·CLKS_PER_BIT.
  - Stop sample and `valid` rise at E+2+HALF+9·CLKS_PER_BIT. With the default parameters this is E+106.
- `frame_err` and `overrun` are high for exactly one cycle, on the stop-sample edge.
- Back-to-back frames: IDLE is entered on the stop-sample edge, so a start edge arriving half a bit later is caught. Sampling tolerance is about ±HALF clocks of cumulative drift per frame.
- All outputs are registered; no combinational path from `rx` or `ready` to any output.

## Structure
- Package `uart_pkg`:
  - state enum `rx_state_t` (IDLE, START, DATA, STOP, BREAK).
  - `UART_CLKS_PER_BIT_DEFAULT` = 11.
  - `UART_DATA_W` = 8.
- Sub-module `uart_sync2`: 2-flop synchroniser with async active-low reset to 1.
- Remainder in one module: FSM, counters, shift register, output register. Estimated 150–250 lines total.

## Test plan
- Loopback: transmitter (`END_OF_COUNTER`=10) sends 0xA5 into `rx`, `ready`=1. Expect `valid` for one cycle with `data`=0xA5, `frame_err`=0, `overrun`=0.
- Glitch: `rx` low for 3 clocks, then high. Expect no `valid` and the FSM back in IDLE; a following 0x3C frame is received correctly.
- Framing: drive a frame for 0x81 with stop bit 0 and the line low for 40 clocks after. Expect a `frame_err` pulse, no `valid`, and no new frame until the line returns high.
- Overrun: `ready`=0, send 0x11 then 0x22. Expect `valid`=1 with `data`=0x11, and an `overrun` pulse at the second stop sample; raising `ready` then shows 0x11 accepted and `valid`=0.
- Simultaneous accept and load: hold `valid` with 0x11, then pulse `ready` exactly on the stop-sample edge of a 0x22 frame. Expect `valid` to stay 1, `data`=0x22, no `overrun`.
- Reset mid-frame: assert `rst_n`=0 during bit 4 of a frame. Expect all outputs 0 immediately, and the next full frame 0x5A received correctly.
